// File: rtl/qeciphy_tx_channelencoder.sv
// qeciphy_tx_channelencoder
// Transmit-side channel encoder. Emits one 64-bit line word per clock while
// enabled. Every PERIOD words it inserts a frame alignment word (FAW) that
// carries a marker, the local rx-ready flag, a sequence number, the mask of
// valid payload slots and a CRC-16 (CCITT, MSB first) over the preceding
// payload slots.
// Optional feature macro: QECIPHY_TX_CRC_INJECT_EN adds inject_crc_err_i,
// which corrupts bit 16 of the next FAW for link-error testing.
module qeciphy_tx_channelencoder #(
    parameter int unsigned PERIOD   = 16,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic [63:0] tdata_i,
    input  logic        tvalid_i,
    output logic        tready_o,
    input  logic        rx_rdy_i,
`ifdef QECIPHY_TX_CRC_INJECT_EN
    input  logic        inject_crc_err_i,
`endif
    output logic [63:0] tdata_o,
    output logic        tx_active_o
);

    // Slot index that carries the FAW; payload slots are 0 .. PERIOD-2.
    localparam logic [3:0]  FAW_SLOT   = 4'(PERIOD - 1);
    // Mask bits that correspond to real payload slots for this PERIOD.
    localparam logic [14:0] MASK_VALID = 15'((32'd1 << (PERIOD - 1)) - 32'd1);

    // CRC-16 CCITT (poly 0x1021), no reflection, whole word absorbed MSB first.
    function automatic logic [15:0] crc16(input logic [15:0] crc_in, input logic [63:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 63; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [3:0]  slot_cnt, slot_cnt_nxt;
    logic [15:0] crc_acc,  crc_acc_nxt;
    logic [14:0] mask,     mask_nxt;
    logic [3:0]  seq,      seq_nxt;
    logic [63:0] word_nxt;
    logic [63:0] payload;
    logic        faw_slot;
    logic        crc_flip;
`ifdef QECIPHY_TX_CRC_INJECT_EN
    logic        inject_flag, inject_flag_nxt;
`endif

    // Payload is accepted in every slot except the FAW slot.
    assign faw_slot = (slot_cnt == FAW_SLOT);
    assign tready_o = enable_i && rst_n_i && !faw_slot;

    // Next framing state and next line word.
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        slot_cnt_nxt = slot_cnt;
        crc_acc_nxt  = crc_acc;
        mask_nxt     = mask;
        seq_nxt      = seq;
        word_nxt     = '0;
        crc_flip     = 1'b0;
        payload      = tvalid_i ? tdata_i : 64'h0;
`ifdef QECIPHY_TX_CRC_INJECT_EN
        crc_flip        = inject_flag && faw_slot;
        // A pulse on the FAW that consumes a pending flag is absorbed.
        inject_flag_nxt = faw_slot ? (!inject_flag && inject_crc_err_i)
                                   : (inject_flag || inject_crc_err_i);
`endif
        if (faw_slot) begin
            word_nxt     = {8'hBC, rx_rdy_i, 3'b000, seq, 1'b0, mask & MASK_VALID,
                            crc_acc ^ {15'h0, crc_flip}, 16'h5A5A};
            crc_acc_nxt  = CRC_INIT;
            mask_nxt     = '0;
            seq_nxt      = seq + 4'd1;
            slot_cnt_nxt = '0;
        end else begin
            // Idle slots still occupy the line as zero words and enter the CRC.
            word_nxt     = payload;
            mask_nxt     = mask | (tvalid_i ? (15'd1 << slot_cnt) : 15'd0);
            crc_acc_nxt  = crc16(crc_acc, payload);
            slot_cnt_nxt = slot_cnt + 4'd1;
        end
    end

    // Framing state and registered output; reset or disable restarts framing
    // so the first word after enable is always a fresh FAW.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !enable_i) begin
            slot_cnt    <= FAW_SLOT;
            crc_acc     <= CRC_INIT;
            mask        <= '0;
            seq         <= '0;
            tdata_o     <= '0;
            tx_active_o <= 1'b0;
        end else begin
            slot_cnt    <= slot_cnt_nxt;
            crc_acc     <= crc_acc_nxt;
            mask        <= mask_nxt;
            seq         <= seq_nxt;
            tdata_o     <= word_nxt;
            tx_active_o <= 1'b1;
        end
    end

`ifdef QECIPHY_TX_CRC_INJECT_EN
    // Sticky CRC-corruption request, consumed by the next FAW.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !enable_i) inject_flag <= 1'b0;
        else                       inject_flag <= inject_flag_nxt;
    end
`endif

endmodule
